ysyx_23060203_mem_arbiter: RTL

//  Shares the single data-memory port between two requesters: IFU (instruction fetch, read-only) and LSU (load/store).

---
 rtl/ysyx_23060203_mem_arbiter_pkg.sv | 33 +++
 rtl/ysyx_23060203_mem_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_mem_arbiter_pkg.sv
// Shared memory-interface constants: LD_*/ST_* funct3 codes, requester encoding
// and the two-way round-robin pick used by the data-memory arbiter.
package ysyx_23060203_mem_arbiter_pkg;

    localparam logic [2:0] LD_BS = 3'b000;
    localparam logic [2:0] LD_HS = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [2:0] ST_B  = 3'b000;
    localparam logic [2:0] ST_H  = 3'b001;
    localparam logic [2:0] ST_W  = 3'b010;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // On a tie the requester that did not own the previous transaction wins.
    function automatic owner_e rr_pick(input logic ifu_v, input logic lsu_v, input owner_e last);
        owner_e pick;
        if (ifu_v && lsu_v) begin
            pick = (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (lsu_v) begin
            pick = OWN_LSU;
        end else begin
            pick = OWN_IFU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU fetches and LSU
// loads/stores; one transaction in flight, IDLE -> ISSUE -> RESP.
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [2:0]        lsu_func,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_ren,
    output logic [2:0]        mem_rfunc,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [2:0]        mem_wfunc,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e             state_q;
    owner_e             last_owner_q;
    owner_e             owner_q;
    logic               wen_q;
    logic [2:0]         func_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;

    owner_e             grant_s;
    logic               idle_s;
    logic               issue_s;
    logic               resp_s;
    logic               accept_s;
    logic               owner_ready_s;

    // Grant and handshake decode; rst masks every strobe in the reset cycle.
    always_comb begin
        grant_s        = rr_pick(ifu_req_valid, lsu_req_valid, last_owner_q);
        idle_s         = (state_q == S_IDLE)  && !rst;
        issue_s        = (state_q == S_ISSUE) && !rst;
        resp_s         = (state_q == S_RESP)  && !rst;

        ifu_req_ready  = idle_s && ifu_req_valid && (grant_s == OWN_IFU);
        lsu_req_ready  = idle_s && lsu_req_valid && (grant_s == OWN_LSU);
        accept_s       = ifu_req_ready || lsu_req_ready;

        ifu_resp_valid = resp_s && (owner_q == OWN_IFU);
        lsu_resp_valid = resp_s && (owner_q == OWN_LSU);
        ifu_rdata      = (owner_q == OWN_IFU) ? rdata_q : '0;
        lsu_rdata      = (owner_q == OWN_LSU) ? rdata_q : '0;
        owner_ready_s  = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

        mem_ren        = issue_s && !wen_q;
        mem_wen        = issue_s &&  wen_q;
        mem_rfunc      = func_q;
        mem_wfunc      = func_q;
        mem_raddr      = addr_q;
        mem_waddr      = addr_q;
        mem_wdata      = wdata_q;
    end

    // Transaction FSM and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWN_LSU;
            owner_q      <= OWN_IFU;
            wen_q        <= 1'b0;
            func_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        owner_q      <= grant_s;
                        last_owner_q <= grant_s;
                        if (grant_s == OWN_IFU) begin
                            wen_q   <= 1'b0;
                            func_q  <= LD_W;
                            addr_q  <= ifu_addr;
                            wdata_q <= '0;
                        end else begin
                            wen_q   <= lsu_wen;
                            func_q  <= lsu_func;
                            addr_q  <= lsu_addr;
                            wdata_q <= lsu_wdata;
                        end
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    rdata_q <= wen_q ? '0 : mem_rdata;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (owner_ready_s) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
